// File: rtl/clcd_pkg.sv
// Shared definitions for the character-LCD write arbiter: state encoding,
// HD44780 command bytes, the registered bus record and the set-address helper.
package clcd_pkg;

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_FSET  = 3'd1;
    localparam logic [2:0] S_DON   = 3'd2;
    localparam logic [2:0] S_EMODE = 3'd3;
    localparam logic [2:0] S_CLR   = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd5;
    localparam logic [2:0] S_ADDR  = 3'd6;
    localparam logic [2:0] S_DATA  = 3'd7;

    localparam logic [7:0] CLCD_FSET    = 8'h38;
    localparam logic [7:0] CLCD_DON     = 8'h0C;
    localparam logic [7:0] CLCD_EMODE   = 8'h06;
    localparam logic [7:0] CLCD_CLR     = 8'h01;
    localparam logic [7:0] CLCD_SETADDR = 8'h80;
    localparam logic [7:0] CLCD_LINE2   = 8'h40;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } clcd_bus_t;

    function automatic logic [7:0] clcd_addr_cmd(input logic row, input logic [3:0] col);
        return CLCD_SETADDR | (row ? CLCD_LINE2 : 8'h00) | {4'h0, col};
    endfunction

endpackage

// File: rtl/clcd_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer holding
// the last granted requester (a tie goes to the requester that is not the pointer).
module clcd_rr_arb2
    import clcd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr_r;

    // grant selection
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        if (en) begin
            case (req)
                2'b01: begin gnt = 2'b01; gnt_idx = 1'b0; end
                2'b10: begin gnt = 2'b10; gnt_idx = 1'b1; end
                2'b11: begin
                    if (ptr_r) begin
                        gnt = 2'b01; gnt_idx = 1'b0;
                    end else begin
                        gnt = 2'b10; gnt_idx = 1'b1;
                    end
                end
                default: begin gnt = 2'b00; gnt_idx = 1'b0; end
            endcase
        end else begin
            gnt     = 2'b00;
            gnt_idx = 1'b0;
        end
    end

    // pointer remembers the last winner; reset value lets requester 0 win the first tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= 1'b1;
        end else if (gnt != 2'b00) begin
            ptr_r <= gnt_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/clcd_write_arbiter.sv
// Character-LCD bus owner: power-up init, then arbitrated single-character writes.
// Optional macro CLCD_ADDR_SKIP_EN skips set-address when the target equals the cursor.
module clcd_write_arbiter
    import clcd_pkg::*;
#(
    parameter int unsigned INIT_WAIT  = 70,
    parameter int unsigned CMD_CYCLES = 30,
    parameter int unsigned CLR_CYCLES = 200,
    parameter int unsigned WR_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req,
    input  logic [1:0]  req_row,
    input  logic [7:0]  req_col,
    input  logic [15:0] req_char,
    output logic [1:0]  ack,
    output logic        init_done,
    output logic        busy,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic [7:0]  LCD_DATA
);

    logic [2:0] state_r, state_nx_s;
    logic [7:0] cnt_r, cnt_nx_s, len_s;
    logic       done_s, gnt_en_s, grant_s, hit_s;
    logic [1:0] gnt_s;
    logic       gnt_idx_s;
    logic       win_row_s, row_nx_s, lat_row_r;
    logic [3:0] win_col_s, col_nx_s, lat_col_r;
    logic [7:0] win_char_s, char_nx_s, lat_char_r;
    logic       who_nx_s, lat_who_r;
    clcd_bus_t  bus_nx_s, bus_r;
    logic [1:0] ack_nx_s, ack_r;
    logic       init_done_r, busy_r;

    // no grant while ack is showing, so the finished requester gets a cycle to drop req
    assign gnt_en_s = (state_r == S_IDLE) && (ack_r == 2'b00);

    clcd_rr_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .en      (gnt_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign grant_s    = (gnt_s != 2'b00);
    assign win_row_s  = gnt_idx_s ? req_row[1]     : req_row[0];
    assign win_col_s  = gnt_idx_s ? req_col[7:4]   : req_col[3:0];
    assign win_char_s = gnt_idx_s ? req_char[15:8] : req_char[7:0];
    assign row_nx_s   = grant_s ? win_row_s  : lat_row_r;
    assign col_nx_s   = grant_s ? win_col_s  : lat_col_r;
    assign char_nx_s  = grant_s ? win_char_s : lat_char_r;
    assign who_nx_s   = grant_s ? gnt_idx_s  : lat_who_r;

`ifdef CLCD_ADDR_SKIP_EN
    logic [6:0] cursor_r;
    logic       cursor_vld_r;

    assign hit_s = cursor_vld_r && (cursor_r == {win_row_s, 2'b00, win_col_s});

    // DDRAM cursor shadow: loaded by set-address, advanced by each data write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cursor_r     <= 7'd0;
            cursor_vld_r <= 1'b0;
        end else if (state_r == S_CLR) begin
            cursor_r     <= 7'd0;
            cursor_vld_r <= 1'b0;
        end else if ((state_r == S_ADDR) && done_s) begin
            cursor_r     <= {lat_row_r, 2'b00, lat_col_r};
            cursor_vld_r <= 1'b1;
        end else if ((state_r == S_DATA) && done_s) begin
            cursor_r     <= cursor_r + 7'd1;
            cursor_vld_r <= cursor_vld_r;
        end else begin
            cursor_r     <= cursor_r;
            cursor_vld_r <= cursor_vld_r;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    // length of the current state, timed by the single shared counter
    always_comb begin
        case (state_r)
            S_WAIT:                 len_s = 8'(INIT_WAIT);
            S_FSET, S_DON, S_EMODE: len_s = 8'(CMD_CYCLES);
            S_CLR:                  len_s = 8'(CLR_CYCLES);
            S_ADDR, S_DATA:         len_s = 8'(WR_CYCLES);
            default:                len_s = 8'd1;
        endcase
        done_s = (cnt_r == (len_s - 8'd1));
    end

    // state sequencing
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_WAIT:  if (done_s) state_nx_s = S_FSET;  else state_nx_s = S_WAIT;
            S_FSET:  if (done_s) state_nx_s = S_DON;   else state_nx_s = S_FSET;
            S_DON:   if (done_s) state_nx_s = S_EMODE; else state_nx_s = S_DON;
            S_EMODE: if (done_s) state_nx_s = S_CLR;   else state_nx_s = S_EMODE;
            S_CLR:   if (done_s) state_nx_s = S_IDLE;  else state_nx_s = S_CLR;
            S_IDLE:  if (grant_s) state_nx_s = hit_s ? S_DATA : S_ADDR; else state_nx_s = S_IDLE;
            S_ADDR:  if (done_s) state_nx_s = S_DATA;  else state_nx_s = S_ADDR;
            S_DATA:  if (done_s) state_nx_s = S_IDLE;  else state_nx_s = S_DATA;
            default: state_nx_s = S_WAIT;
        endcase
        if ((state_nx_s != state_r) || (state_r == S_IDLE)) begin
            cnt_nx_s = 8'd0;
        end else begin
            cnt_nx_s = cnt_r + 8'd1;
        end
    end

    // bus drive for the upcoming cycle, so the registered pins line up with the state
    always_comb begin
        bus_nx_s.e    = 1'b0;
        bus_nx_s.rs   = 1'b0;
        bus_nx_s.rw   = 1'b1;
        bus_nx_s.data = 8'h00;
        case (state_nx_s)
            S_FSET:  bus_nx_s.data = CLCD_FSET;
            S_DON:   bus_nx_s.data = CLCD_DON;
            S_EMODE: bus_nx_s.data = CLCD_EMODE;
            S_CLR:   bus_nx_s.data = CLCD_CLR;
            S_ADDR:  bus_nx_s.data = clcd_addr_cmd(row_nx_s, col_nx_s);
            S_DATA:  begin bus_nx_s.rs = 1'b1; bus_nx_s.data = char_nx_s; end
            default: bus_nx_s.data = 8'h00;
        endcase
        if ((state_nx_s != S_WAIT) && (state_nx_s != S_IDLE)) begin
            bus_nx_s.rw = 1'b0;
            bus_nx_s.e  = (cnt_nx_s == 8'd1);
        end else begin
            bus_nx_s.rw = 1'b1;
            bus_nx_s.e  = 1'b0;
        end
        if ((state_r == S_DATA) && (state_nx_s == S_IDLE)) begin
            ack_nx_s = lat_who_r ? 2'b10 : 2'b01;
        end else begin
            ack_nx_s = 2'b00;
        end
    end

    // state, counter, latched payload and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_WAIT;
            cnt_r       <= 8'd0;
            lat_row_r   <= 1'b0;
            lat_col_r   <= 4'd0;
            lat_char_r  <= 8'h00;
            lat_who_r   <= 1'b0;
            bus_r       <= '{e: 1'b0, rs: 1'b0, rw: 1'b1, data: 8'h00};
            ack_r       <= 2'b00;
            init_done_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            lat_row_r   <= row_nx_s;
            lat_col_r   <= col_nx_s;
            lat_char_r  <= char_nx_s;
            lat_who_r   <= who_nx_s;
            bus_r       <= bus_nx_s;
            ack_r       <= ack_nx_s;
            init_done_r <= init_done_r | ((state_r == S_CLR) && (state_nx_s == S_IDLE));
            busy_r      <= (state_nx_s != S_IDLE);
        end
    end

    assign ack       = ack_r;
    assign init_done = init_done_r;
    assign busy      = busy_r;
    assign LCD_E     = bus_r.e;
    assign LCD_RS    = bus_r.rs;
    assign LCD_RW    = bus_r.rw;
    assign LCD_DATA  = bus_r.data;

endmodule
